// File: rtl/crop_ctrl.sv
// crop_ctrl: sequencer between the slave-side stream FIFO and the AXI-Stream master output.
// Pops one beat at a time, tracks pixel x/y from the FIFO SOF (user) and EOL (last) bits and
// forwards only the beats that fall inside the crop window latched on SOF. TUSER and TLAST are
// regenerated for the cropped frame.
//
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESETN            clock, asynchronous active-low reset
//   enable                                  start-of-frame enable, sampled on SOF beats only
//   crop_x0/y0/w/h                          crop window, latched on SOF
//   fifo_rd_en                              registered FIFO read strobe
//   fifo_data/user/last                     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty                              registered FIFO empty flag
//   M_AXIS_TVALID/TREADY/TDATA/TUSER/TLAST  cropped output stream
//   busy                                    a frame is being processed
//   frame_done                              pulse on acceptance of the last window beat
module crop_ctrl #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_DIM_WIDTH          = 12
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  input  logic                            enable,
  input  logic [C_DIM_WIDTH-1:0]          crop_x0,
  input  logic [C_DIM_WIDTH-1:0]          crop_y0,
  input  logic [C_DIM_WIDTH-1:0]          crop_w,
  input  logic [C_DIM_WIDTH-1:0]          crop_h,
  output logic                            fifo_rd_en,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_data,
  input  logic                            fifo_user,
  input  logic                            fifo_last,
  input  logic                            fifo_empty,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TUSER,
  output logic                            M_AXIS_TLAST,
  output logic                            busy,
  output logic                            frame_done
);

  typedef logic [C_DIM_WIDTH-1:0] dim_t;
  typedef logic [C_DIM_WIDTH:0]   ext_t;

  localparam dim_t DimOne = dim_t'(1);
  localparam dim_t DimMax = '1;
  localparam ext_t ExtOne = ext_t'(1);

  // IdleRd/IdleCap pop and inspect beats while waiting for an enabled SOF.
  typedef enum logic [2:0] {
    StIdle, StIdleRd, StIdleCap, StFetch, StRead, StCapture, StOutput
  } state_e;

  state_e state_q, state_d;
  dim_t   x_q, x_d, y_q, y_d;
  dim_t   x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic   first_q, first_d;
  logic   tvalid_q, tvalid_d;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic   tuser_q, tuser_d, tlast_q, tlast_d;
  logic   done_beat_q, done_beat_d;
  logic   beat_last_q, beat_last_d;
  logic   rd_en_q;

  // Effective frame context for the beat being evaluated: an SOF substitutes fresh config
  // and pixel (0,0) in the same cycle it is captured.
  logic   start, eval_beat, eff_first, keep, row_end, last_row, adv_last;
  dim_t   eff_x, eff_y, eff_x0, eff_y0, eff_w, eff_h, adv_x, adv_y;
  ext_t   x_lim, y_lim;

  always_comb begin
    start = fifo_user & enable & ((state_q == StIdleCap) | (state_q == StCapture));
    if (start) begin
      eff_x     = '0;
      eff_y     = '0;
      eff_x0    = crop_x0;
      eff_y0    = crop_y0;
      eff_w     = crop_w;
      eff_h     = crop_h;
      eff_first = 1'b1;
    end else begin
      eff_x     = x_q;
      eff_y     = y_q;
      eff_x0    = x0_q;
      eff_y0    = y0_q;
      eff_w     = w_q;
      eff_h     = h_q;
      eff_first = first_q;
    end
    // Exclusive window limits, one bit wider so they never wrap.
    x_lim    = {1'b0, eff_x0} + {1'b0, eff_w};
    y_lim    = {1'b0, eff_y0} + {1'b0, eff_h};
    keep     = (eff_x >= eff_x0) && ({1'b0, eff_x} < x_lim) &&
               (eff_y >= eff_y0) && ({1'b0, eff_y} < y_lim);
    // A short input line (EOL before the window edge) also terminates the output line.
    row_end  = ({1'b0, eff_x} == (x_lim - ExtOne)) | fifo_last;
    last_row = ({1'b0, eff_y} == (y_lim - ExtOne));
    adv_last = (state_q == StOutput) ? beat_last_q : fifo_last;
    if (adv_last) begin
      adv_x = '0;
      adv_y = (eff_y == DimMax) ? eff_y : eff_y + DimOne;
    end else begin
      adv_x = (eff_x == DimMax) ? eff_x : eff_x + DimOne;
      adv_y = eff_y;
    end
    eval_beat = ((state_q == StIdleCap) && start) ||
                ((state_q == StCapture) && !(fifo_user && !enable));
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    first_d     = first_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    done_beat_d = done_beat_q;
    beat_last_d = beat_last_q;

    unique case (state_q)
      StIdle:    if (!fifo_empty) state_d = StIdleRd;
      StIdleRd:  state_d = StIdleCap;
      StIdleCap: if (!start) state_d = StIdle;
      StFetch:   if (!fifo_empty) state_d = StRead;
      StRead:    state_d = StCapture;
      StCapture: if (fifo_user && !enable) state_d = StIdle;
      StOutput: begin
        if (M_AXIS_TREADY) begin
          tvalid_d = 1'b0;
          first_d  = 1'b0;
          x_d      = adv_x;
          y_d      = adv_y;
          state_d  = StFetch;
        end
      end
      default:   state_d = StIdle;
    endcase

    if (eval_beat) begin
      x0_d    = eff_x0;
      y0_d    = eff_y0;
      w_d     = eff_w;
      h_d     = eff_h;
      first_d = eff_first;
      if (keep) begin
        // Counters hold the kept pixel until it is accepted.
        tvalid_d    = 1'b1;
        tdata_d     = fifo_data;
        tuser_d     = eff_first;
        tlast_d     = row_end;
        done_beat_d = last_row;
        beat_last_d = fifo_last;
        x_d         = eff_x;
        y_d         = eff_y;
        state_d     = StOutput;
      end else begin
        x_d     = adv_x;
        y_d     = adv_y;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      first_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      done_beat_q <= 1'b0;
      beat_last_q <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      first_q     <= first_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      done_beat_q <= done_beat_d;
      beat_last_q <= beat_last_d;
      // Read states are only entered after a cycle of non-empty with no pop in flight,
      // so pulses are single-cycle and at least two cycles apart.
      rd_en_q     <= (state_d == StIdleRd) || (state_d == StRead);
    end
  end

  assign fifo_rd_en    = rd_en_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign busy          = (state_q != StIdle) && (state_q != StIdleRd) && (state_q != StIdleCap);
  assign frame_done    = tvalid_q & M_AXIS_TREADY & tlast_q & done_beat_q;

endmodule

// File: doc/crop_ctrl.md
Name: crop_ctrl

Overview:
- Sequencing controller between the slave-side stream FIFO (read port) and the AXI-Stream master output of the crop core.
- Pops one beat at a time from the FIFO and tracks pixel x/y from the FIFO's user (SOF) and last (EOL) bits.
- Forwards only the beats that fall inside the configured crop window, regenerating TUSER and TLAST for the cropped frame.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, pixel beat width; the FIFO data and M_AXIS_TDATA widths match it.
- C_DIM_WIDTH, 12, width of the coordinate counters and the crop configuration inputs.

Ports:
- S_AXIS_ACLK  in  1  single clock for the block.
- S_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
- enable  in  1  sampled only on SOF beats.
- crop_x0, crop_y0  in  C_DIM_WIDTH  window origin; latched on SOF.
- crop_w, crop_h  in  C_DIM_WIDTH  window size; latched on SOF.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_data  in  C_S_AXIS_TDATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_user  in  1  FIFO SOF bit; valid the cycle after fifo_rd_en.
- fifo_last  in  1  FIFO EOL bit; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag (registered).
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  C_S_AXIS_TDATA_WIDTH  output pixel.
- M_AXIS_TUSER  out  1  first kept pixel of the frame.
- M_AXIS_TLAST  out  1  last kept pixel of each cropped line.
- busy  out  1  high when the state is not IDLE.
- frame_done  out  1  one-cycle pulse when the last window beat is accepted.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. fifo_rd_en, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, busy and frame_done are all 0. x, y, the config registers and the first_kept flag are all 0.
- fifo_rd_en is a registered output and must be decoded from state only.
- FIFO read cadence:
  - fifo_rd_en is asserted only when fifo_empty=0.
  - Each pulse is one cycle; the minimum spacing between pulses is 2 cycles.
  - This spacing lets the registered empty flag reflect the previous pop and is mandatory.
  - Data is captured the cycle after fifo_rd_en.
- States:
  - IDLE: pop beats whenever fifo_empty=0 and discard them. A captured beat with user=1 and enable=1 latches the config, sets x=0, y=0, first_kept=1, evaluates that beat as pixel (0,0), then follows the normal path.
  - FETCH: if fifo_empty=0, assert fifo_rd_en and go to CAPTURE; otherwise stay.
  - CAPTURE: the beat is valid this cycle.
    - user=1: restart the frame with the same latching as IDLE. With enable=0, go to IDLE and drop the beat.
    - keep=1: load the M_AXIS outputs, set TVALID and go to OUTPUT.
    - keep=0: advance the counters and go to FETCH.
  - OUTPUT: hold TVALID and data stable until M_AXIS_TREADY=1. On the accept cycle, advance the counters, drop TVALID (unless refilled) and go to FETCH.
- Keep rule:
  - keep = (x >= x0) and (x < x0+w) and (y >= y0) and (y < y0+h).
  - Sums are computed at C_DIM_WIDTH+1 bits, so there is no wrap.
  - w=0 or h=0 means no beat is ever kept.
- Output flags:
  - M_AXIS_TUSER = first_kept on the kept beat; first_kept clears when that beat is accepted.
  - M_AXIS_TLAST = (x == x0+w-1) on the kept beat.
  - An input EOL on a kept beat with x < x0+w-1 (short line) also sets TLAST.
- Counter advance:
  - last=1: x=0, y=y+1.
  - last=0: x=x+1.
  - Both counters saturate at all-ones; they never wrap.
- frame_done: 1-cycle pulse on the accept cycle of a kept beat with TLAST=1 and y == y0+h-1.
- Throughput: at most 1 kept beat per 2 cycles with TREADY held high.
- Dropped beats never stall on TREADY.
- Config inputs are ignored except on SOF capture.
- Reset mid-frame returns to IDLE immediately.
- An SOF arriving mid-window while in CAPTURE restarts the frame. Any beat already in OUTPUT completes first.

Test Plan:
- 8x4 frame, window x0=2 y0=1 w=3 h=2, TREADY=1. Expected: 6 output beats, pixels (2..4,1) and (2..4,2). TUSER only on (2,1). TLAST on x=4 for both lines. One frame_done pulse.
- Same frame with TREADY toggling 1-0-0-1 random. Expected: no beat lost or duplicated, TDATA stable while TVALID=1 and TREADY=0, and fifo_rd_en stays low while in OUTPUT.
- FIFO goes empty mid-line (fifo_empty=1 for 5 cycles). Expected: fifo_rd_en=0 throughout and no spurious output. Two fifo_rd_en pulses are never closer than 2 cycles.
- w=0, or x0=10 on an 8-wide frame. Expected: zero output beats and no frame_done. The FIFO still drains and busy=1 until the next SOF.
- Second SOF after 3 lines of a 4-line frame, with new config x0=0 w=2. Expected: counters restart and the new window applies. The first output of the new frame carries TUSER=1.
- Async reset asserted while in OUTPUT with TVALID=1. Expected: M_AXIS_TVALID=0 immediately and state=IDLE. After release, non-SOF beats are dropped until an SOF arrives.
